pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, 32, PC width in bits; WIDTH SHALL be at least 8.
REQ-002 Parameter RESET_VEC, 32'h80000000, PC value loaded on reset.
REQ-003 Parameter ILLOP_VEC, 32'h80000004, illegal-op trap target.
REQ-004 Parameter XADR_VEC, 32'h80000008, interrupt trap target.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 RESET  in  1  reset, asynchronous, active-high.
REQ-007 JT  in  WIDTH  jump target (JMP).
REQ-008 SXT  in  16  signed branch displacement in words.
REQ-009 PCSEL  in  3  next-PC select: 0 PC_INC, 1 branch, 2 JMP, 3 ILLOP, 4 XADR, 5-7 treated as 3.
REQ-010 IRQ  in  1  interrupt request level.
REQ-011 STALL  in  1  hold current instruction; blocks PC update.
REQ-012 FETCH_READY  in  1  instruction memory accepts current fetch address.
REQ-013 PC  out  WIDTH  current fetch address, registered.
REQ-014 PC_INC  out  WIDTH  PC+4, combinational.
REQ-015 PC_OFFSET  out  WIDTH  branch target, combinational.
REQ-016 FETCH_VALID  out  1  PC is a valid fetch request, registered.
REQ-017 IRQ_TAKEN  out  1  one-cycle pulse on interrupt vectoring, registered.

Function
REQ-018 Supervisor bit S = PC[WIDTH-1]; PC[1:0] SHALL always be 00.
REQ-019 PC_INC = {S, PC[WIDTH-2:0]+4}, low WIDTH-1 bits wrap modulo 2^(WIDTH-1); S never changed by increment.
REQ-020 PC_OFFSET = {S, (PC_INC + sign_extend(SXT)*4)[WIDTH-2:0]}; wrap modulo 2^(WIDTH-1).
REQ-021 JMP target = {JT[WIDTH-1] & S, JT[WIDTH-2:2], 2'b00}; JMP SHALL never set S from user mode.
REQ-022 ILLOP and XADR targets are ILLOP_VEC and XADR_VEC verbatim (S set).
REQ-023 FSM states BOOT, FETCH, HOLD.
REQ-024 BOOT: FETCH_VALID=0; unconditionally -> FETCH next cycle; PC unchanged.
REQ-025 FETCH: FETCH_VALID=1; FETCH_READY=0 -> stay, PC unchanged.
REQ-026 FETCH with FETCH_READY=1, STALL=0 -> advance event, stay FETCH.
REQ-027 FETCH with FETCH_READY=1, STALL=1 -> HOLD, PC unchanged, FETCH_VALID=0 next cycle.
REQ-028 HOLD: STALL=1 -> stay; STALL=0 -> advance event, -> FETCH.
REQ-029 Advance event: PC loads target selected by PCSEL in the same cycle; one update per event, latency 1 cycle.
REQ-030 IRQ high in any cycle SHALL set sticky flag irq_pend; held until taken or reset.
REQ-031 On advance event with (irq_pend|IRQ)=1 and S=0: PC<=XADR_VEC overriding PCSEL, irq_pend cleared, IRQ_TAKEN=1 next cycle.
REQ-032 With S=1, interrupts SHALL NOT be taken; irq_pend retained until an advance event occurs with S=0.
REQ-033 IRQ_TAKEN SHALL be 0 in all cycles not following an interrupt-taking advance.
REQ-034 PCSEL, JT, SXT sampled only at advance events; ignored otherwise.

Reset
REQ-035 RESET high SHALL immediately, without CLK: PC=RESET_VEC, state BOOT, FETCH_VALID=0, IRQ_TAKEN=0, irq_pend=0.
REQ-036 Reset asserted mid-HOLD or mid-FETCH SHALL abandon the pending update; first advance after release occurs no earlier than 2 rising edges after deassertion.

Verification
REQ-037 Reset release, FETCH_READY=1, STALL=0, PCSEL=0 for 4 cycles -> FETCH_VALID 0 then 1; PC 80000000, 80000004, 80000008, 8000000C.
REQ-038 PC=00000100, PCSEL=1, SXT=16'hFFFE -> PC_OFFSET=000000FC, PC=000000FC next cycle; SXT=3 -> 00000110.
REQ-039 PC=00000040 (user), PCSEL=2, JT=80001237 -> PC=00001234; from S=1 same JT -> 80001234.
REQ-040 PC=00000200, one-cycle IRQ pulse while FETCH_READY=0, then FETCH_READY=1, PCSEL=0 -> PC=80000008, IRQ_TAKEN pulses once; IRQ at S=1 -> no trap until S=0.
REQ-041 STALL=1 during FETCH_READY for 3 cycles, PCSEL=2, JT=00000500 -> PC held, FETCH_VALID=0 in HOLD; STALL=0 -> PC=00000500, FETCH_VALID=1.
REQ-042 RESET pulse between clock edges while in HOLD -> PC=80000000 and FETCH_VALID=0 before next CLK edge; PCSEL=7 at advance -> PC=80000004.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with fetch handshake, supervisor-protected jumps,
//            trap vectors and sticky interrupt vectoring.
// Revision : 1.0
// ============================================================================
module pc_unit #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h80000000,
    parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h80000004,
    parameter logic [WIDTH-1:0] XADR_VEC  = 32'h80000008
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] JT,
    input  logic [15:0]      SXT,
    input  logic [2:0]       PCSEL,
    input  logic             IRQ,
    input  logic             STALL,
    input  logic             FETCH_READY,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_INC,
    output logic [WIDTH-1:0] PC_OFFSET,
    output logic             FETCH_VALID,
    output logic             IRQ_TAKEN
);

    localparam int             c_SXT_W = WIDTH - 3;
    localparam logic [WIDTH-2:0] c_INC = (WIDTH-1)'(4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_fetch_valid;
    logic             r_irq_taken;
    logic             r_irq_pend;

    logic             w_sup;
    logic [WIDTH-4:0] w_sxt;
    logic [WIDTH-2:0] w_disp;
    logic [WIDTH-2:0] w_inc_low;
    logic [WIDTH-2:0] w_off_low;
    logic [WIDTH-1:0] w_jmp;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_advance;
    logic             w_take;
    logic             w_unused_jt;

    // Arithmetic stays inside the low WIDTH-1 bits so the supervisor bit is
    // never disturbed by increments or branch offsets.
    assign w_sup     = r_pc[WIDTH-1];
    assign w_sxt     = c_SXT_W'($signed(SXT));
    assign w_disp    = {w_sxt, 2'b00};
    assign w_inc_low = r_pc[WIDTH-2:0] + c_INC;
    assign w_off_low = w_inc_low + w_disp;
    assign PC_INC    = {w_sup, w_inc_low};
    assign PC_OFFSET = {w_sup, w_off_low};

    // A user-mode jump can never raise the supervisor bit.
    assign w_jmp       = {JT[WIDTH-1] & w_sup, JT[WIDTH-2:2], 2'b00};
    assign w_unused_jt = ^JT[1:0];

    always_comb begin
        w_target = ILLOP_VEC;
        case (PCSEL)
            3'd0:    w_target = PC_INC;
            3'd1:    w_target = PC_OFFSET;
            3'd2:    w_target = w_jmp;
            3'd4:    w_target = XADR_VEC;
            default: w_target = ILLOP_VEC;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (FETCH_READY) begin
                    if (STALL) begin
                        w_next_state = ST_HOLD;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!STALL) begin
                    w_advance    = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

    // Interrupts are only vectored from user mode, overriding PCSEL.
    assign w_take    = w_advance & (r_irq_pend | IRQ) & ~w_sup;
    assign w_next_pc = w_take ? XADR_VEC : w_target;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VEC;
            r_fetch_valid <= 1'b0;
            r_irq_taken   <= 1'b0;
            r_irq_pend    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_fetch_valid <= (w_next_state == ST_FETCH);
            r_irq_taken   <= w_take;
            r_irq_pend    <= (r_irq_pend | IRQ) & ~w_take;
            if (w_advance) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign PC          = r_pc;
    assign FETCH_VALID = r_fetch_valid;
    assign IRQ_TAKEN   = r_irq_taken;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Self-checking bench for pc_unit: directed scenarios plus random
//            stimulus against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] RESET_VEC = 32'h80000000;
    localparam logic [31:0] ILLOP_VEC = 32'h80000004;
    localparam logic [31:0] XADR_VEC  = 32'h80000008;
    localparam longint      MOD31     = 64'sd2147483648;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] JT;
    logic [15:0] SXT;
    logic [2:0]  PCSEL;
    logic        IRQ;
    logic        STALL;
    logic        FETCH_READY;
    logic [31:0] PC;
    logic [31:0] PC_INC;
    logic [31:0] PC_OFFSET;
    logic        FETCH_VALID;
    logic        IRQ_TAKEN;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC value and what the unit is currently doing.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_hold;
    bit          m_pend;
    bit          m_taken;

    pc_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .JT(JT), .SXT(SXT), .PCSEL(PCSEL),
        .IRQ(IRQ), .STALL(STALL), .FETCH_READY(FETCH_READY),
        .PC(PC), .PC_INC(PC_INC), .PC_OFFSET(PC_OFFSET),
        .FETCH_VALID(FETCH_VALID), .IRQ_TAKEN(IRQ_TAKEN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] f_inc(input logic [31:0] pc);
        longint low;
        low = (longint'(pc[30:0]) + 4) % MOD31;
        return {pc[31], 31'(low)};
    endfunction

    function automatic logic [31:0] f_off(input logic [31:0] pc, input logic [15:0] sxt);
        logic [31:0] inc;
        longint      low;
        inc = f_inc(pc);
        low = (longint'(inc[30:0]) + longint'($signed(sxt)) * 4) % MOD31;
        if (low < 0) low = low + MOD31;
        return {pc[31], 31'(low)};
    endfunction

    function automatic logic [31:0] f_target(input logic [31:0] pc, input logic [2:0] sel,
                                             input logic [31:0] jt, input logic [15:0] sxt);
        case (sel)
            3'd0:    return f_inc(pc);
            3'd1:    return f_off(pc, sxt);
            3'd2:    return {jt[31] & pc[31], jt[30:2], 2'b00};
            3'd4:    return XADR_VEC;
            default: return ILLOP_VEC;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RESET_VEC; m_boot = 1; m_hold = 0; m_pend = 0; m_taken = 0;
    endtask

    // One rising edge: model predicts from pre-edge inputs, then outputs settle.
    task automatic tick();
        bit          fetching, adv, take;
        logic [31:0] tgt;
        fetching = !m_boot && !m_hold;
        adv      = (fetching && FETCH_READY && !STALL) || (m_hold && !STALL);
        take     = adv && (m_pend || IRQ) && !m_pc[31];
        tgt      = f_target(m_pc, PCSEL, JT, SXT);
        @(posedge CLK);
        #1;
        if (m_boot) m_boot = 0;
        else if (fetching && FETCH_READY && STALL) m_hold = 1;
        else if (m_hold && !STALL) m_hold = 0;
        m_pend  = (m_pend || IRQ) && !take;
        m_taken = take;
        if (adv) m_pc = take ? XADR_VEC : tgt;
    endtask

    task automatic test_reset();
        RESET = 0; JT = '0; SXT = '0; PCSEL = '0; IRQ = 0; STALL = 0; FETCH_READY = 0;
        #2 RESET = 1;
        #1;
        model_reset();
        n_tests++; if (PC !== RESET_VEC) begin n_fail++; $display("FAIL reset_async_pc: got %h expected %h", PC, RESET_VEC); end
        n_tests++; if (FETCH_VALID !== 1'b0 || IRQ_TAKEN !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got fv=%b taken=%b expected 0 0", FETCH_VALID, IRQ_TAKEN); end
        n_tests++; if (PC_INC !== 32'h80000004) begin n_fail++; $display("FAIL reset_pc_inc: got %h expected %h", PC_INC, 32'h80000004); end
        @(posedge CLK); #1;
        n_tests++; if (PC !== RESET_VEC || FETCH_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_held: got pc=%h fv=%b expected %h 0", PC, FETCH_VALID, RESET_VEC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h80000000, 32'h80000004, 32'h80000008, 32'h8000000C};
        FETCH_READY = 1; STALL = 0; PCSEL = 3'd0;
        RESET = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (PC !== exp_pc[k] || FETCH_VALID !== 1'b1) begin n_fail++; $display("FAIL seq_cycle%0d: got pc=%h fv=%b expected %h 1", k, PC, FETCH_VALID, exp_pc[k]); end
        end
    endtask

    task automatic test_branch();
        PCSEL = 3'd2; JT = 32'h00000100; tick();
        n_tests++; if (PC !== 32'h00000100) begin n_fail++; $display("FAIL branch_setup: got %h expected %h", PC, 32'h00000100); end
        PCSEL = 3'd1; SXT = 16'hFFFE; #1;
        n_tests++; if (PC_OFFSET !== 32'h000000FC || PC_INC !== 32'h00000104) begin n_fail++; $display("FAIL branch_comb: got off=%h inc=%h expected 000000fc 00000104", PC_OFFSET, PC_INC); end
        tick();
        n_tests++; if (PC !== 32'h000000FC) begin n_fail++; $display("FAIL branch_back: got %h expected %h", PC, 32'h000000FC); end
        PCSEL = 3'd2; JT = 32'h00000100; tick();
        PCSEL = 3'd1; SXT = 16'h0003; tick();
        n_tests++; if (PC !== 32'h00000110) begin n_fail++; $display("FAIL branch_fwd: got %h expected %h", PC, 32'h00000110); end
    endtask

    task automatic test_jmp();
        PCSEL = 3'd2; JT = 32'h00000040; tick();
        JT = 32'h80001237; tick();
        n_tests++; if (PC !== 32'h00001234) begin n_fail++; $display("FAIL jmp_user: got %h expected %h", PC, 32'h00001234); end
        PCSEL = 3'd3; tick();
        n_tests++; if (PC !== ILLOP_VEC) begin n_fail++; $display("FAIL jmp_illop: got %h expected %h", PC, ILLOP_VEC); end
        PCSEL = 3'd2; JT = 32'h80001237; tick();
        n_tests++; if (PC !== 32'h80001234) begin n_fail++; $display("FAIL jmp_super: got %h expected %h", PC, 32'h80001234); end
    endtask

    task automatic test_irq();
        PCSEL = 3'd2; JT = 32'h00000200; tick();
        FETCH_READY = 0; IRQ = 1; tick();
        IRQ = 0; tick();
        n_tests++; if (PC !== 32'h00000200 || IRQ_TAKEN !== 1'b0) begin n_fail++; $display("FAIL irq_wait: got pc=%h taken=%b expected 00000200 0", PC, IRQ_TAKEN); end
        FETCH_READY = 1; PCSEL = 3'd0; tick();
        n_tests++; if (PC !== XADR_VEC || IRQ_TAKEN !== 1'b1) begin n_fail++; $display("FAIL irq_take: got pc=%h taken=%b expected %h 1", PC, IRQ_TAKEN, XADR_VEC); end
        tick();
        n_tests++; if (PC !== 32'h8000000C || IRQ_TAKEN !== 1'b0) begin n_fail++; $display("FAIL irq_once: got pc=%h taken=%b expected 8000000c 0", PC, IRQ_TAKEN); end
        IRQ = 1; tick();
        IRQ = 0; tick();
        n_tests++; if (PC !== 32'h80000014 || IRQ_TAKEN !== 1'b0) begin n_fail++; $display("FAIL irq_super: got pc=%h taken=%b expected 80000014 0", PC, IRQ_TAKEN); end
        PCSEL = 3'd2; JT = 32'h00000300; tick();
        n_tests++; if (PC !== 32'h00000300) begin n_fail++; $display("FAIL irq_to_user: got %h expected %h", PC, 32'h00000300); end
        PCSEL = 3'd0; tick();
        n_tests++; if (PC !== XADR_VEC || IRQ_TAKEN !== 1'b1) begin n_fail++; $display("FAIL irq_pend_take: got pc=%h taken=%b expected %h 1", PC, IRQ_TAKEN, XADR_VEC); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = PC;
        FETCH_READY = 1; STALL = 1; PCSEL = 3'd2; JT = 32'h00000500;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (PC !== held || FETCH_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got pc=%h fv=%b expected %h 0", k, PC, FETCH_VALID, held); end
        end
        STALL = 0; tick();
        n_tests++; if (PC !== 32'h00000500 || FETCH_VALID !== 1'b1) begin n_fail++; $display("FAIL stall_release: got pc=%h fv=%b expected 00000500 1", PC, FETCH_VALID); end
    endtask

    task automatic test_reset_hold();
        FETCH_READY = 1; STALL = 1; PCSEL = 3'd0; tick();
        #3 RESET = 1;
        #1;
        n_tests++; if (PC !== RESET_VEC || FETCH_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_hold_async: got pc=%h fv=%b expected %h 0", PC, FETCH_VALID, RESET_VEC); end
        #1 RESET = 0;
        model_reset();
        STALL = 0; PCSEL = 3'd7; tick();
        n_tests++; if (PC !== RESET_VEC || FETCH_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_hold_boot: got pc=%h fv=%b expected %h 1", PC, FETCH_VALID, RESET_VEC); end
        tick();
        n_tests++; if (PC !== ILLOP_VEC) begin n_fail++; $display("FAIL rst_hold_sel7: got %h expected %h", PC, ILLOP_VEC); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            FETCH_READY = ($urandom_range(0, 3) != 0);
            STALL       = ($urandom_range(0, 3) == 0);
            PCSEL       = 3'($urandom_range(0, 7));
            JT          = $urandom;
            SXT         = 16'($urandom);
            IRQ         = ($urandom_range(0, 7) == 0);
            tick();
            n_tests++;
            if (PC !== m_pc || FETCH_VALID !== (!m_boot && !m_hold) || IRQ_TAKEN !== m_taken
                || PC_INC !== f_inc(m_pc) || PC_OFFSET !== f_off(m_pc, SXT)) begin
                n_fail++;
                $display("FAIL random%0d: got pc=%h fv=%b tk=%b inc=%h off=%h expected %h %b %b %h %h",
                         k, PC, FETCH_VALID, IRQ_TAKEN, PC_INC, PC_OFFSET,
                         m_pc, !m_boot && !m_hold, m_taken, f_inc(m_pc), f_off(m_pc, SXT));
            end
            if ($urandom_range(0, 49) == 0) begin
                RESET = 1;
                #2;
                n_tests++; if (PC !== RESET_VEC || FETCH_VALID !== 1'b0 || IRQ_TAKEN !== 1'b0) begin n_fail++; $display("FAIL random_rst%0d: got pc=%h fv=%b tk=%b expected %h 0 0", k, PC, FETCH_VALID, IRQ_TAKEN, RESET_VEC); end
                RESET = 0;
                model_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jmp();
        test_irq();
        test_stall();
        test_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
